// File: rtl/jtkiwi_pkg.sv
// ============================================================================
// Module      : jtkiwi_pkg
// Description : Sound-CPU memory-map page codes and select decoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package jtkiwi_pkg;

  localparam logic [3:0] PAGE_BANK   = 4'hA;
  localparam logic [3:0] PAGE_FM     = 4'hB;
  localparam logic [3:0] PAGE_CAB    = 4'hC;
  localparam logic [3:0] PAGE_RAM_LO = 4'hD;
  localparam logic [3:0] PAGE_RAM_HI = 4'hE;

  typedef struct packed {
    logic rom;
    logic bank;
    logic fm;
    logic cab;
    logic mcu;
    logic ram;
  } sel_t;

  // At most one field is ever set; page 0xF decodes to nothing.
  function automatic sel_t page_decode(input logic [3:0] page, input logic mcu_en,
                                       input logic mem_acc);
    sel_t s;
    s = '0;
    if (mem_acc) begin
      if (page < PAGE_BANK)                              s.rom  = 1'b1;
      else if (page == PAGE_BANK)                        s.bank = 1'b1;
      else if (page == PAGE_FM)                          s.fm   = 1'b1;
      else if (page == PAGE_CAB)                         begin
        s.cab = ~mcu_en;
        s.mcu = mcu_en;
      end
      else if (page == PAGE_RAM_LO || page == PAGE_RAM_HI) s.ram = 1'b1;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtkiwi_wdog.sv
// ============================================================================
// Module      : jtkiwi_wdog
// Description : Frame watchdog; pulses wd_rstn low when the CPU stops banking.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jtkiwi_wdog #(
  parameter int WDOG_FRAMES = 8,
  parameter int WDOG_RSTLEN = 16
) (
  input  logic clk,
  input  logic comb_rstn,
  input  logic lvbl_fall,
  input  logic clr,
  output logic wd_rstn
);

  localparam int              FW         = $clog2(WDOG_FRAMES + 1);
  localparam int              PW         = $clog2(WDOG_RSTLEN + 1);
  localparam logic [FW-1:0]   FRAMES_MAX = FW'(WDOG_FRAMES);
  localparam logic [PW-1:0]   PULSE_LEN  = PW'(WDOG_RSTLEN);

  logic [FW-1:0] frames_d, frames_q;
  logic [PW-1:0] pulse_d, pulse_q;
  logic          wd_rstn_d, wd_rstn_q;

  // While a pulse runs the frame count is frozen; it restarts at 0 afterwards.
  always_comb begin
    frames_d  = frames_q;
    pulse_d   = pulse_q;
    wd_rstn_d = wd_rstn_q;
    if (pulse_q != '0) begin
      pulse_d = pulse_q - PW'(1);
      if (pulse_q == PW'(1)) begin
        wd_rstn_d = 1'b1;
        frames_d  = '0;
      end
    end else if (clr) begin
      frames_d = '0;
    end else if (frames_q == FRAMES_MAX) begin
      pulse_d   = PULSE_LEN;
      wd_rstn_d = 1'b0;
    end else if (lvbl_fall) begin
      frames_d = frames_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      frames_q  <= '0;
      pulse_q   <= '0;
      wd_rstn_q <= 1'b1;
    end else begin
      frames_q  <= frames_d;
      pulse_q   <= pulse_d;
      wd_rstn_q <= wd_rstn_d;
    end
  end

  assign wd_rstn = wd_rstn_q;

endmodule

`default_nettype wire

// File: rtl/jtkiwi_sndbus.sv
// ============================================================================
// Module      : jtkiwi_sndbus
// Description : Sound-CPU bus glue: selects, ROM banking, VBL IRQ, waits, watchdog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jtkiwi_sndbus
  import jtkiwi_pkg::*;
#(
  parameter int BANKW       = 2,
  parameter int WDOG_EN     = 1,
  parameter int WDOG_FRAMES = 8,
  parameter int WDOG_RSTLEN = 16
) (
  input  logic                clk,
  input  logic                comb_rstn,
  input  logic                cen6,
  input  logic                LVBL,
  input  logic                mreq_n,
  input  logic                rfsh_n,
  input  logic                iorq_n,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic [15:0]         A,
  input  logic [7:0]          dout,
  input  logic                mcu_en,
  input  logic                mshramen,
  output logic [14+BANKW-1:0] rom_addr,
  output logic                rom_cs,
  output logic                bank_cs,
  output logic                fm_cs,
  output logic                cab_cs,
  output logic                mcu_cs,
  output logic                ram_cs,
  output logic [BANKW-1:0]    bank,
  output logic                mcu_rstn,
  output logic                int_n,
  output logic                dev_busy,
  output logic                wd_rstn
);

  localparam int ROMW = 14 + BANKW;

  logic             mem_acc;
  logic             lvbl_fall;
  sel_t             sel_d, sel_q;
  logic [BANKW-1:0] bank_d, bank_q;
  logic             mcu_rstn_d, mcu_rstn_q;
  logic             lvbl_q;
  logic             int_n_d, int_n_q;
  logic             fm_last_d, fm_last_q;
  logic             fm_busy_d, fm_busy_q;
  logic             unused_pins;

  assign unused_pins = ^{rd_n, wr_n, dout};

  always_comb begin
    mem_acc    = ~mreq_n & rfsh_n;
    sel_d      = page_decode(A[15:12], mcu_en, mem_acc);
    lvbl_fall  = lvbl_q & ~LVBL;
    bank_d     = bank_q;
    mcu_rstn_d = mcu_rstn_q;
    if (sel_q.bank) begin
      bank_d     = dout[BANKW-1:0];
      mcu_rstn_d = dout[BANKW+2];
    end
    // A new VBL edge outranks an acknowledge in the same cycle.
    int_n_d = int_n_q;
    if (lvbl_fall)    int_n_d = 1'b0;
    else if (!iorq_n) int_n_d = 1'b1;
    fm_last_d = fm_last_q;
    fm_busy_d = fm_busy_q;
    if (cen6) begin
      fm_last_d = sel_q.fm;
      fm_busy_d = sel_q.fm & ~fm_last_q;
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      sel_q      <= '0;
      bank_q     <= '0;
      mcu_rstn_q <= 1'b0;
      lvbl_q     <= 1'b1;
      int_n_q    <= 1'b1;
      fm_last_q  <= 1'b0;
      fm_busy_q  <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      bank_q     <= bank_d;
      mcu_rstn_q <= mcu_rstn_d;
      lvbl_q     <= LVBL;
      int_n_q    <= int_n_d;
      fm_last_q  <= fm_last_d;
      fm_busy_q  <= fm_busy_d;
    end
  end

  assign rom_addr = A[15] ? {1'b1, bank_q, A[12:0]} : ROMW'(A[14:0]);
  assign rom_cs   = sel_q.rom;
  assign bank_cs  = sel_q.bank;
  assign fm_cs    = sel_q.fm;
  assign cab_cs   = sel_q.cab;
  assign mcu_cs   = sel_q.mcu;
  assign ram_cs   = sel_q.ram;
  assign bank     = bank_q;
  assign mcu_rstn = mcu_rstn_q;
  assign int_n    = int_n_q;
  assign dev_busy = (mshramen & sel_q.ram) | fm_busy_q;

  generate
    if (WDOG_EN != 0) begin : g_wdog
      jtkiwi_wdog #(
        .WDOG_FRAMES (WDOG_FRAMES),
        .WDOG_RSTLEN (WDOG_RSTLEN)
      ) u_wdog (
        .clk       (clk),
        .comb_rstn (comb_rstn),
        .lvbl_fall (lvbl_fall),
        .clr       (sel_q.bank),
        .wd_rstn   (wd_rstn)
      );
    end else begin : g_no_wdog
      assign wd_rstn = 1'b1;
    end
  endgenerate

endmodule

`default_nettype wire
